// File: rtl/btn_debounce_pkg.sv
// Shared types and default timing constants for the button debouncer.
// Pure declarations; no logic.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_e;

    // 10 ms debounce and 1 s long-hold at the 50 MHz PLL clock
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500_000;
    localparam int HOLD_CYCLES_DEFAULT     = 50_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pin into the clk_i domain.
// Latency: 2 clk_i cycles. Backpressure: none, samples every cycle.
// Reset loads RESET_VAL into both flops so the output starts at a known idle level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/btn_debounce.sv
// Debounces the active-low user button into a clean level plus press/release/hold strobes.
// Latency: DEBOUNCE_CYCLES+3 clk_i edges from a clean pin edge to the press/release strobe.
// Backpressure: none; strobes are single-cycle and must be consumed when high.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic pressed_o,
    output logic press_o,
    output logic release_o,
    output logic hold_o
);

    localparam int CNT_MAX = max_int(DEBOUNCE_CYCLES, HOLD_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_PRE = CNT_W'(HOLD_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("btn_debounce: HOLD_CYCLES must be >= 1");
    end

    logic             btn_sync;
    logic             btn_s;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             pressed_d, press_d, release_d, hold_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (btn_ni),
        .q_o    (btn_sync)
    );

    assign btn_s   = ~btn_sync;
    assign cnt_inc = (cnt_q == CNT_TOP) ? cnt_q : cnt_q + CNT_ONE;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            pressed_o <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            hold_o    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pressed_o <= pressed_d;
            press_o   <= press_d;
            release_o <= release_d;
            hold_o    <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pressed_d = pressed_o;
        press_d   = 1'b0;
        release_d = 1'b0;
        hold_d    = 1'b0;
        case (state_q)
            RELEASED: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LIM) begin
                    state_d   = PRESSED;
                    pressed_d = 1'b1;
                    press_d   = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                // Strobe on the step into HOLD_LIM so the count then parks without re-firing
                if (cnt_q == HOLD_PRE) begin
                    hold_d = 1'b1;
                end
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q != HOLD_LIM) begin
                    cnt_d = cnt_inc;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = PRESSED;
                    cnt_d   = HOLD_LIM;
                end else if (cnt_q == DEB_LIM) begin
                    state_d   = RELEASED;
                    pressed_d = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce with DEBOUNCE_CYCLES=8, HOLD_CYCLES=20.
module tb_btn_debounce;
    import btn_debounce_pkg::*;

    localparam int DEB  = 8;
    localparam int HOLD = 20;
    localparam int LAT  = DEB + 3;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    logic btn_ni = 1'b1;
    logic pressed_o, press_o, release_o, hold_o;

    int checks = 0;
    int fails  = 0;

    // Reference: the level flips once the synchronized button has disagreed with it
    // for DEB+1 consecutive samples; hold fires HOLD edges after a press if the
    // synchronized button never dropped in between.
    logic m_s0 = 1'b1, m_s1 = 1'b1, m_bs = 1'b0;
    logic m_level = 1'b0, m_intr = 1'b0;
    logic e_press = 1'b0, e_rel = 1'b0, e_hold = 1'b0;
    int   m_run = 0, m_age = 0;

    always #10 clk_i = ~clk_i;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .btn_ni    (btn_ni),
        .pressed_o (pressed_o),
        .press_o   (press_o),
        .release_o (release_o),
        .hold_o    (hold_o)
    );

    always @(posedge clk_i) begin
        if (!rst_ni) begin
            m_s0 = 1'b1; m_s1 = 1'b1; m_level = 1'b0; m_intr = 1'b0;
            m_run = 0; m_age = 0;
            e_press = 1'b0; e_rel = 1'b0; e_hold = 1'b0;
        end else begin
            m_bs = !m_s1;
            e_press = 1'b0; e_rel = 1'b0; e_hold = 1'b0;
            if (m_level) begin
                m_age = m_age + 1;
                if (m_age == HOLD && !m_intr) e_hold = 1'b1;
                if (!m_bs && m_age < HOLD) m_intr = 1'b1;
            end
            m_run = (m_bs != m_level) ? m_run + 1 : 0;
            if (m_run == DEB + 1) begin
                m_level = !m_level;
                m_run   = 0;
                if (m_level) begin
                    e_press = 1'b1; m_age = 0; m_intr = 1'b0;
                end else begin
                    e_rel = 1'b1;
                end
            end
            m_s1 = m_s0;
            m_s0 = btn_ni;
        end
    end

    task automatic test_reset();
        rst_ni = 1'b0;
        btn_ni = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({pressed_o, press_o, release_o, hold_o} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 0000", {pressed_o, press_o, release_o, hold_o});
        end
        rst_ni = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            checks++;
            if ({pressed_o, press_o, release_o, hold_o} !== 4'b0000) begin
                fails++;
                $display("FAIL idle_outputs: cycle %0d got %b expected 0000", k, {pressed_o, press_o, release_o, hold_o});
            end
            checks++;
            if (dut.state_q !== RELEASED) begin
                fails++;
                $display("FAIL idle_state: cycle %0d got %0d expected %0d", k, dut.state_q, RELEASED);
            end
        end
    endtask

    task automatic test_press();
        @(negedge clk_i);
        btn_ni = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk_i);
            checks++;
            if (press_o !== (k == LAT) || pressed_o !== (k == LAT)) begin
                fails++;
                $display("FAIL press_latency: edge %0d got press=%b pressed=%b expected %b", k, press_o, pressed_o, (k == LAT));
            end
            checks++;
            if ({pressed_o, press_o, release_o, hold_o} !== {m_level, e_press, e_rel, e_hold}) begin
                fails++;
                $display("FAIL press_model: edge %0d got %b expected %b", k, {pressed_o, press_o, release_o, hold_o}, {m_level, e_press, e_rel, e_hold});
            end
        end
    endtask

    // Continues straight from the press_o cycle
    task automatic test_hold();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_i);
            checks++;
            if (hold_o !== (k == HOLD) || pressed_o !== 1'b1 || press_o !== 1'b0) begin
                fails++;
                $display("FAIL hold_pulse: cycle %0d got hold=%b pressed=%b press=%b expected hold=%b", k, hold_o, pressed_o, press_o, (k == HOLD));
            end
        end
        btn_ni = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk_i);
            checks++;
            if (release_o !== 1'b0 || hold_o !== 1'b0 || pressed_o !== 1'b1) begin
                fails++;
                $display("FAIL release_bounce: cycle %0d got rel=%b hold=%b pressed=%b expected 0 0 1", k, release_o, hold_o, pressed_o);
            end
            checks++;
            if ({pressed_o, press_o, release_o, hold_o} !== {m_level, e_press, e_rel, e_hold}) begin
                fails++;
                $display("FAIL bounce_model: cycle %0d got %b expected %b", k, {pressed_o, press_o, release_o, hold_o}, {m_level, e_press, e_rel, e_hold});
            end
            if (k == 4) btn_ni = 1'b0;
        end
    endtask

    task automatic test_release();
        @(negedge clk_i);
        btn_ni = 1'b1;
        for (int k = 1; k <= LAT + 3; k++) begin
            @(negedge clk_i);
            checks++;
            if (release_o !== (k == LAT) || pressed_o !== (k < LAT)) begin
                fails++;
                $display("FAIL release_latency: edge %0d got rel=%b pressed=%b expected %b %b", k, release_o, pressed_o, (k == LAT), (k < LAT));
            end
            checks++;
            if ({pressed_o, press_o, release_o, hold_o} !== {m_level, e_press, e_rel, e_hold}) begin
                fails++;
                $display("FAIL release_model: edge %0d got %b expected %b", k, {pressed_o, press_o, release_o, hold_o}, {m_level, e_press, e_rel, e_hold});
            end
        end
    endtask

    task automatic test_bounce_press();
        @(negedge clk_i);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                btn_ni = (c < 5) ? 1'b0 : 1'b1;
                @(negedge clk_i);
                checks++;
                if (press_o !== 1'b0 || pressed_o !== 1'b0) begin
                    fails++;
                    $display("FAIL bounce_reject: round %0d cycle %0d got press=%b pressed=%b expected 0 0", r, c, press_o, pressed_o);
                end
            end
        end
        btn_ni = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk_i);
            checks++;
            if (press_o !== (k == LAT) || pressed_o !== (k == LAT)) begin
                fails++;
                $display("FAIL bounce_press: edge %0d got press=%b pressed=%b expected %b", k, press_o, pressed_o, (k == LAT));
            end
        end
    endtask

    task automatic test_coincide();
        @(negedge clk_i);
        btn_ni = 1'b0;
        repeat (LAT) @(negedge clk_i);
        checks++;
        if (press_o !== 1'b1) begin
            fails++;
            $display("FAIL coincide_press: got %b expected 1", press_o);
        end
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk_i);
            checks++;
            if (hold_o !== (k == HOLD) || release_o !== (k == 17 + LAT)) begin
                fails++;
                $display("FAIL coincide_strobes: cycle %0d got hold=%b rel=%b expected %b %b", k, hold_o, release_o, (k == HOLD), (k == 17 + LAT));
            end
            if (k == HOLD) begin
                checks++;
                if (dut.state_q !== RELEASE_WAIT) begin
                    fails++;
                    $display("FAIL coincide_state: got %0d expected %0d", dut.state_q, RELEASE_WAIT);
                end
            end
            if (k == 17) btn_ni = 1'b1;
        end
    endtask

    task automatic test_random();
        logic q[$];
        int   n_press = 0, n_rel = 0;
        logic last_press = 1'b0;
        for (int i = 0; i < 10; i++) begin
            q.delete();
            repeat ($urandom_range(1, 4)) begin
                repeat ($urandom_range(1, 7)) q.push_back(1'b0);
                repeat ($urandom_range(1, 4)) q.push_back(1'b1);
            end
            repeat ($urandom_range(LAT + 1, 40)) q.push_back(1'b0);
            repeat ($urandom_range(1, 4)) begin
                repeat ($urandom_range(1, 7)) q.push_back(1'b1);
                repeat ($urandom_range(1, 4)) q.push_back(1'b0);
            end
            repeat (LAT + 4) q.push_back(1'b1);
            foreach (q[j]) begin
                btn_ni = q[j];
                @(negedge clk_i);
                checks++;
                if ({pressed_o, press_o, release_o, hold_o} !== {m_level, e_press, e_rel, e_hold}) begin
                    fails++;
                    $display("FAIL random_model: press %0d step %0d got %b expected %b", i, j, {pressed_o, press_o, release_o, hold_o}, {m_level, e_press, e_rel, e_hold});
                end
                if (press_o || release_o) begin
                    checks++;
                    if (press_o === last_press) begin
                        fails++;
                        $display("FAIL random_alternate: press %0d got press=%b after last_press=%b", i, press_o, last_press);
                    end
                    last_press = press_o;
                    if (press_o) n_press++; else n_rel++;
                end
            end
        end
        checks++;
        if (n_press != 10 || n_rel != 10) begin
            fails++;
            $display("FAIL random_counts: got press=%0d release=%0d expected 10 10", n_press, n_rel);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        btn_ni = 1'b0;
        repeat (5) @(negedge clk_i);
        checks++;
        if (dut.state_q !== PRESS_WAIT) begin
            fails++;
            $display("FAIL rmid_state: got %0d expected %0d", dut.state_q, PRESS_WAIT);
        end
        rst_ni = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({pressed_o, press_o, release_o, hold_o} !== 4'b0000 || dut.state_q !== RELEASED) begin
            fails++;
            $display("FAIL rmid_reset: got outputs %b state %0d expected 0000 %0d", {pressed_o, press_o, release_o, hold_o}, dut.state_q, RELEASED);
        end
        rst_ni = 1'b1;
        for (int k = 1; k <= LAT + 2; k++) begin
            @(negedge clk_i);
            checks++;
            if (press_o !== (k == LAT) || pressed_o !== (k >= LAT)) begin
                fails++;
                $display("FAIL rmid_press: edge %0d got press=%b pressed=%b expected %b %b", k, press_o, pressed_o, (k == LAT), (k >= LAT));
            end
            checks++;
            if ({pressed_o, press_o, release_o, hold_o} !== {m_level, e_press, e_rel, e_hold}) begin
                fails++;
                $display("FAIL rmid_model: edge %0d got %b expected %b", k, {pressed_o, press_o, release_o, hold_o}, {m_level, e_press, e_rel, e_hold});
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_hold();
        test_release();
        test_bounce_press();
        test_release();
        test_coincide();
        repeat (5) @(negedge clk_i);
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
